// File: rtl/demux_1to4.sv
// Registered 1-to-4 demultiplexer with per-lane saturating hit counters.
// A sample {i, s1, s0} is taken on any rising edge where in_valid is high.
// There is no back-pressure. The consumer sees y/lane_oh qualified by
// out_valid one cycle later, and every lane not selected reads zero.
module demux_1to4 #(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   i,
  input  logic                s0,
  input  logic                s1,
  input  logic                in_valid,
  output logic [4*DATA_W-1:0] y,
  output logic                out_valid,
  output logic [3:0]          lane_oh,
  input  logic [1:0]          cnt_sel,
  output logic [CNT_W-1:0]    cnt_out,
  input  logic                cnt_clr
);

  logic [1:0]          sel;
  logic [4*DATA_W-1:0] y_next;
  logic [3:0]          lane_oh_next;
  logic [CNT_W-1:0]    cnt [4];

  assign sel = {s1, s0};

  // Steer i onto the selected lane and zero the rest; nothing is routed when invalid.
  always_comb begin
    y_next       = '0;
    lane_oh_next = '0;
    for (int k = 0; k < 4; k++) begin
      if (in_valid && (sel == 2'(k))) begin
        y_next[k*DATA_W +: DATA_W] = i;
        lane_oh_next[k]            = 1'b1;
      end
    end
  end

  // Output registers: one cycle of latency, reset forces everything low.
  always_ff @(posedge clk) begin
    if (rst) begin
      y         <= '0;
      lane_oh   <= '0;
      out_valid <= 1'b0;
    end else begin
      y         <= y_next;
      lane_oh   <= lane_oh_next;
      out_valid <= in_valid;
    end
  end

  // Hit counters: clear beats increment, and each counter sticks at all-ones.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst || cnt_clr) begin
        cnt[k] <= '0;
      end else if (lane_oh_next[k] && (cnt[k] != {CNT_W{1'b1}})) begin
        cnt[k] <= cnt[k] + CNT_W'(1);
      end
    end
  end

  assign cnt_out = cnt[cnt_sel];

endmodule

// File: tb/tb_demux_1to4.sv
// Self-checking bench for demux_1to4 with 8-bit lanes and 4-bit counters.
// The model works on whole-word shifts and integer counters.
module tb_demux_1to4;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int YW     = 4 * DATA_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Clock and reset signals
  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] i;
  logic              s0, s1, in_valid, cnt_clr;
  logic [1:0]        cnt_sel;
  logic [YW-1:0]     y;
  logic              out_valid;
  logic [3:0]        lane_oh;
  logic [CNT_W-1:0]  cnt_out;

  always #5 clk = ~clk;

  demux_1to4 #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i(i), .s0(s0), .s1(s1), .in_valid(in_valid),
    .y(y), .out_valid(out_valid), .lane_oh(lane_oh),
    .cnt_sel(cnt_sel), .cnt_out(cnt_out), .cnt_clr(cnt_clr)
  );

  // Scoreboard state
  logic [YW-1:0] exp_q[$];
  logic          exp_valid;
  logic [3:0]    exp_oh;
  int            exp_cnt [4];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: apply the sampled inputs of one edge.
  task automatic model_edge(input logic [DATA_W-1:0] di, input int ds, input logic dv,
                            input logic dc, input logic dr);
    logic [YW-1:0] ey;
    ey = '0;
    if (dr) begin
      exp_valid = 1'b0;
      exp_oh    = '0;
      for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
    end else begin
      if (dv) begin
        ey        = YW'(di) << (ds * DATA_W);
        exp_oh    = 4'(1 << ds);
        exp_valid = 1'b1;
      end else begin
        exp_oh    = '0;
        exp_valid = 1'b0;
      end
      if (dc) begin
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
      end else if (dv && exp_cnt[ds] < CNT_MAX) begin
        exp_cnt[ds] = exp_cnt[ds] + 1;
      end
    end
    exp_q.push_back(ey);
  endtask

  // Driver: present inputs, take one edge, then check outputs 1 time unit later.
  task automatic step(input logic [DATA_W-1:0] di, input int ds, input logic dv,
                      input logic dc, input logic dr);
    i = di; s1 = ds[1]; s0 = ds[0]; in_valid = dv; cnt_clr = dc; rst = dr;
    @(posedge clk);
    model_edge(di, ds, dv, dc, dr);
    #1;
    check("y", 64'(y), 64'(exp_q.pop_front()));
    check("out_valid", 64'(out_valid), 64'(exp_valid));
    check("lane_oh", 64'(lane_oh), 64'(exp_oh));
    check("cnt_out", 64'(cnt_out), 64'(exp_cnt[cnt_sel]));
  endtask

  // Read back every counter through the combinational read port.
  task automatic read_counters(input string tag);
    for (int k = 0; k < 4; k++) begin
      cnt_sel = 2'(k);
      #1;
      check(tag, 64'(cnt_out), 64'(exp_cnt[k]));
    end
  endtask

  initial begin
    cnt_sel = 2'd0;
    exp_valid = 1'b0;
    exp_oh = '0;
    for (int k = 0; k < 4; k++) exp_cnt[k] = 0;

    // Reset holds everything low even with valid traffic present.
    step(8'd1, 0, 1'b1, 1'b0, 1'b1);
    step(8'd1, 0, 1'b1, 1'b0, 1'b1);
    check("reset_y", 64'(y), 64'd0);
    read_counters("reset_cnt");

    // Lane sweep, select order 00, 10, 01, 11.
    step(8'd1, 0, 1'b1, 1'b0, 1'b0);
    check("sweep_lane0", 64'(y), 64'h0000_0001);
    step(8'd1, 2, 1'b1, 1'b0, 1'b0);
    check("sweep_lane2", 64'(y), 64'h0001_0000);
    step(8'd1, 1, 1'b1, 1'b0, 1'b0);
    check("sweep_lane1", 64'(y), 64'h0000_0100);
    step(8'd1, 3, 1'b1, 1'b0, 1'b0);
    check("sweep_lane3", 64'(y), 64'h0100_0000);

    // A zero data value is still a hit; dropping valid gates everything.
    step(8'd0, 3, 1'b1, 1'b0, 1'b0);
    check("zero_oh", 64'(lane_oh), 64'h8);
    read_counters("zero_cnt");
    step(8'd0, 3, 1'b0, 1'b0, 1'b0);
    check("invalid_ov", 64'(out_valid), 64'd0);
    read_counters("invalid_cnt");

    // Counting, then clear that wins over a simultaneous hit.
    step(8'd0, 0, 1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 5; n++) step(8'($urandom), 2, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) step(8'($urandom), 1, 1'b1, 1'b0, 1'b0);
    cnt_sel = 2'd2; #1; check("count_lane2", 64'(cnt_out), 64'd5);
    cnt_sel = 2'd1; #1; check("count_lane1", 64'(cnt_out), 64'd3);
    read_counters("count_cnt");
    step(8'h3c, 2, 1'b1, 1'b1, 1'b0);
    read_counters("clr_cnt");

    // Saturation at 15 without wrap.
    for (int n = 0; n < 20; n++) step(8'($urandom), 0, 1'b1, 1'b0, 1'b0);
    cnt_sel = 2'd0; #1; check("sat_lane0", 64'(cnt_out), 64'd15);

    // Wide data, then reset mid-stream discards the presented sample.
    step(8'ha5, 1, 1'b1, 1'b0, 1'b0);
    check("wide_y", 64'(y), 64'h0000_a500);
    step(8'h5a, 2, 1'b1, 1'b0, 1'b1);
    check("midrst_y", 64'(y), 64'd0);
    read_counters("midrst_cnt");

    // Random traffic with occasional clear and reset.
    for (int n = 0; n < 400; n++) begin
      cnt_sel = 2'($urandom_range(0, 3));
      step(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 60) == 0));
      if (n % 50 == 49) read_counters("rand_cnt");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
